// File: rtl/sync_pkg.sv
// Shared definitions for the wheel/timer frame-sync generator.
// Holds the operating-mode encoding, default parameter values and the
// quadrature Gray-step lookup used by the decoder.
package sync_pkg;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'b00,
    MODE_TIMER     = 2'b01,
    MODE_WHEEL_FWD = 2'b10,
    MODE_WHEEL_BI  = 2'b11
  } mode_e;

  localparam int unsigned FILT_DEPTH_DEFAULT = 4;
  localparam int unsigned POS_W_DEFAULT      = 32;
  localparam int unsigned DIV_W_DEFAULT      = 16;
  localparam int unsigned RATIO_W_DEFAULT    = 8;
  localparam int unsigned FRAME_CNT_W        = 16;

  // Forward successor of each {a,b} state, packed as {next(11), next(10), next(01), next(00)}.
  // Forward order is 00 -> 10 -> 11 -> 01 -> 00.
  localparam logic [7:0] GRAY_FWD_NEXT = 8'b01_11_00_10;

  function automatic logic [1:0] gray_fwd_next(input logic [1:0] ab);
    return GRAY_FWD_NEXT[{ab, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/wheel_sync_gen_if.sv
// Control/status bundle of wheel_sync_gen.
//   i_ch_a/i_ch_b : raw encoder phases (asynchronous)
//   i_mode        : off / timer / wheel forward-only / wheel bidirectional
//   i_in_sync_div : timer period in clk cycles, 0 disables the timer
//   i_wheel_add   : accumulator increment per encoder step
//   i_frame_dec   : accumulator threshold per sync, 0 disables wheel sync
//   i_pos_clr     : synchronous position clear
//   i_err_clr     : clears the sticky error flag
//   o_step/o_dir/o_pos : step pulse, last direction, signed position
//   o_sync/o_frame_cnt : frame strobe and wrapping sync count
//   o_err         : sticky illegal-transition flag
// master drives the controls (sequencer / bench), slave is the generator.
interface wheel_sync_gen_if #(
  parameter int unsigned POS_W   = sync_pkg::POS_W_DEFAULT,
  parameter int unsigned DIV_W   = sync_pkg::DIV_W_DEFAULT,
  parameter int unsigned RATIO_W = sync_pkg::RATIO_W_DEFAULT
) ();

  logic                        i_ch_a;
  logic                        i_ch_b;
  sync_pkg::mode_e             i_mode;
  logic [DIV_W-1:0]            i_in_sync_div;
  logic [RATIO_W-1:0]          i_wheel_add;
  logic [RATIO_W-1:0]          i_frame_dec;
  logic                        i_pos_clr;
  logic                        i_err_clr;
  logic                        o_step;
  logic                        o_dir;
  logic [POS_W-1:0]            o_pos;
  logic                        o_sync;
  logic [sync_pkg::FRAME_CNT_W-1:0] o_frame_cnt;
  logic                        o_err;

  modport master (
    output i_ch_a, i_ch_b, i_mode, i_in_sync_div, i_wheel_add, i_frame_dec, i_pos_clr, i_err_clr,
    input  o_step, o_dir, o_pos, o_sync, o_frame_cnt, o_err
  );

  modport slave (
    input  i_ch_a, i_ch_b, i_mode, i_in_sync_div, i_wheel_add, i_frame_dec, i_pos_clr, i_err_clr,
    output o_step, o_dir, o_pos, o_sync, o_frame_cnt, o_err
  );

endinterface

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser followed by a debounce for one encoder phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i        : raw asynchronous pin
//   level_o    : debounced level
//   valid_o    : high once a first stable level has been accepted after reset
// A new level is accepted after FILT_DEPTH consecutive equal synchronised samples.
module quad_input_filter
  import sync_pkg::*;
#(
  parameter int unsigned FILT_DEPTH = FILT_DEPTH_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic valid_o
);

  localparam int unsigned CntW = $clog2(FILT_DEPTH);
  localparam logic [CntW-1:0] CntLast = CntW'(FILT_DEPTH - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            valid_q, valid_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!valid_q) begin
      // Before priming level_q tracks the candidate value being qualified.
      if (sync2_q != level_q) begin
        level_d = sync2_q;
        cnt_d   = CntW'(1);
      end else if (cnt_q == CntLast) begin
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/wheel_sync_gen.sv
// Frame-sync generator for the acquisition front-end.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : control/status bundle (see wheel_sync_gen_if)
// Debounces a quadrature encoder, tracks signed position and flags illegal
// transitions. The frame strobe comes either from a wheel accumulator
// (add per step, subtract threshold per sync) or from an internal divider.
module wheel_sync_gen
  import sync_pkg::*;
#(
  parameter int unsigned FILT_DEPTH = FILT_DEPTH_DEFAULT,
  parameter int unsigned POS_W      = POS_W_DEFAULT,
  parameter int unsigned DIV_W      = DIV_W_DEFAULT,
  parameter int unsigned RATIO_W    = RATIO_W_DEFAULT
) (
  input logic             clk,
  input logic             rst_n,
  wheel_sync_gen_if.slave bus
);

  localparam int unsigned AccW = RATIO_W + 2;

  logic a_level, a_valid, b_level, b_valid;

  quad_input_filter #(.FILT_DEPTH(FILT_DEPTH)) u_filt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.i_ch_a),
    .level_o(a_level),
    .valid_o(a_valid)
  );

  quad_input_filter #(.FILT_DEPTH(FILT_DEPTH)) u_filt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.i_ch_b),
    .level_o(b_level),
    .valid_o(b_valid)
  );

  logic [1:0]             ab_cur;
  logic [1:0]             ab_q, ab_d;
  logic                   primed_q, primed_d;
  mode_e                  mode_q;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [DIV_W-1:0]       timer_q, timer_d;
  logic                   step_q, step_d;
  logic                   dir_q, dir_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic                   sync_q, sync_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic                   err_q, err_d;

  logic                   step_fwd, step_rev, bad_trans, mode_chg;
  logic                   wheel_fire, timer_fire;
  logic signed [AccW:0]   acc_ext, add_ext, sum;
  logic signed [AccW-1:0] acc_sat, dec_ext;
  logic [DIV_W-1:0]       div_last;

  assign ab_cur = {a_level, b_level};

  // Quadrature decode.
  always_comb begin
    step_fwd  = 1'b0;
    step_rev  = 1'b0;
    bad_trans = 1'b0;
    ab_d      = ab_q;
    primed_d  = primed_q;
    if (primed_q) begin
      ab_d = ab_cur;
      if (ab_cur != ab_q) begin
        if (ab_cur == gray_fwd_next(ab_q)) begin
          step_fwd = 1'b1;
        end else if (ab_q == gray_fwd_next(ab_cur)) begin
          step_rev = 1'b1;
        end else begin
          bad_trans = 1'b1;
        end
      end
    end else if (a_valid && b_valid) begin
      // First stable pair only seeds the decoder.
      ab_d     = ab_cur;
      primed_d = 1'b1;
    end
  end

  // Wheel accumulator: saturating signed add/subtract, then at most one threshold subtract.
  always_comb begin
    wheel_fire = 1'b0;
    acc_ext    = {acc_q[AccW-1], acc_q};
    add_ext    = $signed({3'b000, bus.i_wheel_add});
    dec_ext    = $signed({2'b00, bus.i_frame_dec});
    sum        = acc_ext;
    if (bus.i_mode == MODE_WHEEL_FWD && step_fwd) begin
      sum = acc_ext + add_ext;
    end else if (bus.i_mode == MODE_WHEEL_BI && step_fwd) begin
      sum = acc_ext + add_ext;
    end else if (bus.i_mode == MODE_WHEEL_BI && step_rev) begin
      sum = acc_ext - add_ext;
    end
    if (sum[AccW] != sum[AccW-1]) begin
      acc_sat = sum[AccW] ? {1'b1, {(AccW-1){1'b0}}} : {1'b0, {(AccW-1){1'b1}}};
    end else begin
      acc_sat = sum[AccW-1:0];
    end
    acc_d = acc_sat;
    if ((bus.i_mode == MODE_WHEEL_FWD || bus.i_mode == MODE_WHEEL_BI) && (step_fwd || step_rev)
        && bus.i_frame_dec != '0 && acc_sat >= dec_ext) begin
      acc_d      = acc_sat - dec_ext;
      wheel_fire = 1'b1;
    end
  end

  // Internal timer: counts 0..div-1, fires on the wrap. A shrunken divider wraps at once.
  always_comb begin
    timer_fire = 1'b0;
    timer_d    = '0;
    div_last   = bus.i_in_sync_div - DIV_W'(1);
    if (bus.i_mode == MODE_TIMER && bus.i_in_sync_div != '0) begin
      if (timer_q >= div_last) begin
        timer_fire = 1'b1;
      end else begin
        timer_d = timer_q + DIV_W'(1);
      end
    end
  end

  // Outputs, position, error and frame count.
  always_comb begin
    mode_chg = (bus.i_mode != mode_q);
    step_d   = step_fwd | step_rev;
    dir_d    = step_fwd ? 1'b1 : (step_rev ? 1'b0 : dir_q);
    pos_d    = pos_q;
    if (bus.i_pos_clr) begin
      pos_d = '0;
    end else if (step_fwd) begin
      pos_d = pos_q + POS_W'(1);
    end else if (step_rev) begin
      pos_d = pos_q - POS_W'(1);
    end
    sync_d  = !mode_chg && (wheel_fire || timer_fire);
    frame_d = sync_d ? frame_q + FRAME_CNT_W'(1) : frame_q;
    err_d   = bad_trans ? 1'b1 : (bus.i_err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_q     <= 2'b00;
      primed_q <= 1'b0;
      mode_q   <= MODE_OFF;
      acc_q    <= '0;
      timer_q  <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b1;
      pos_q    <= '0;
      sync_q   <= 1'b0;
      frame_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ab_q     <= ab_d;
      primed_q <= primed_d;
      mode_q   <= bus.i_mode;
      // A mode change restarts both sync sources from zero.
      acc_q    <= mode_chg ? '0 : acc_d;
      timer_q  <= mode_chg ? '0 : timer_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      sync_q   <= sync_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_step      = step_q;
  assign bus.o_dir       = dir_q;
  assign bus.o_pos       = pos_q;
  assign bus.o_sync      = sync_q;
  assign bus.o_frame_cnt = frame_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_wheel_sync_gen.sv
module tb_wheel_sync_gen;
  import sync_pkg::*;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   miss_cnt;

  wheel_sync_gen_if #(.POS_W(32), .DIV_W(16), .RATIO_W(8)) bus ();

  wheel_sync_gen #(.FILT_DEPTH(4), .POS_W(32), .DIV_W(16), .RATIO_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Pin change to o_step is 2 sync + 4 debounce + 1 decode = 7 cycles.
  task automatic do_step(input logic [1:0] ab, input logic clr, output logic stp,
                         output logic syn);
    bus.i_ch_a = ab[1];
    bus.i_ch_b = ab[0];
    for (int i = 0; i < 6; i++) tick();
    if (clr) bus.i_pos_clr = 1'b1;
    tick();
    stp = bus.o_step;
    syn = bus.o_sync;
    bus.i_pos_clr = 1'b0;
    tick();
  endtask

  logic [1:0]  cur_ab;
  logic        stp, syn;
  logic [6:0]  sync_pat;
  logic [31:0] exp_pos;
  int          n_step, n_sync, t0, t1;

  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    rst_n    = 1'b0;
    bus.i_ch_a = 1'b0;
    bus.i_ch_b = 1'b0;
    bus.i_mode = MODE_OFF;
    bus.i_in_sync_div = '0;
    bus.i_wheel_add = '0;
    bus.i_frame_dec = '0;
    bus.i_pos_clr = 1'b0;
    bus.i_err_clr = 1'b0;
    cur_ab  = 2'b00;
    exp_pos = '0;
    repeat (3) tick();
    check_vec("rst_step", 64'(bus.o_step), 64'd0);
    check_vec("rst_dir", 64'(bus.o_dir), 64'd1);
    check_vec("rst_pos", 64'(bus.o_pos), 64'd0);
    check_vec("rst_sync", 64'(bus.o_sync), 64'd0);
    check_vec("rst_frame", 64'(bus.o_frame_cnt), 64'd0);
    check_vec("rst_err", 64'(bus.o_err), 64'd0);
    rst_n = 1'b1;
    n_step = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.o_step) n_step++;
    end
    check_vec("prime_no_step", 64'(n_step), 64'd0);
    check_vec("prime_no_err", 64'(bus.o_err), 64'd0);

    // Wheel forward-only, add=3 dec=7: sync on steps 3, 5, 7.
    bus.i_mode = MODE_WHEEL_FWD;
    bus.i_wheel_add = 8'd3;
    bus.i_frame_dec = 8'd7;
    repeat (2) tick();
    for (int k = 0; k < 7; k++) begin
      cur_ab = fwd(cur_ab);
      do_step(cur_ab, 1'b0, stp, syn);
      sync_pat[k] = syn;
      check_vec("fwd_step", 64'(stp), 64'd1);
    end
    check_vec("fwd_sync_pat", 64'(sync_pat), 64'b1010100);
    check_vec("fwd_acc", {54'b0, dut.acc_q}, 64'd0);
    check_vec("fwd_frame", 64'(bus.o_frame_cnt), 64'd3);
    check_vec("fwd_pos", 64'(bus.o_pos), 64'd7);
    check_vec("fwd_dir", 64'(bus.o_dir), 64'd1);

    // Step 8 (acc 3), then a 2-cycle glitch on A that must be filtered out.
    cur_ab = fwd(cur_ab);
    do_step(cur_ab, 1'b0, stp, syn);
    check_vec("step8", 64'(stp), 64'd1);
    n_step = 0;
    bus.i_ch_a = ~cur_ab[1];
    tick();
    tick();
    bus.i_ch_a = cur_ab[1];
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.o_step) n_step++;
    end
    check_vec("glitch_no_step", 64'(n_step), 64'd0);

    // Stable A change: step exactly 7 cycles after the pin edge.
    cur_ab = fwd(cur_ab);
    bus.i_ch_a = cur_ab[1];
    bus.i_ch_b = cur_ab[0];
    n_step = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.o_step) n_step++;
    end
    check_vec("lat_early", 64'(n_step), 64'd0);
    tick();
    check_vec("lat_step7", 64'(bus.o_step), 64'd1);
    tick();
    check_vec("lat_single", 64'(bus.o_step), 64'd0);
    check_vec("lat_pos", 64'(bus.o_pos), 64'd9);

    // Both phases flip together: error, no step, position kept.
    cur_ab = ~cur_ab;
    do_step(cur_ab, 1'b0, stp, syn);
    check_vec("err_no_step", 64'(stp), 64'd0);
    check_vec("err_set", 64'(bus.o_err), 64'd1);
    check_vec("err_pos", 64'(bus.o_pos), 64'd9);
    bus.i_err_clr = 1'b1;
    tick();
    bus.i_err_clr = 1'b0;
    check_vec("err_clr", 64'(bus.o_err), 64'd0);

    // Bidirectional: 4 reverse -> acc -12, 4 forward -> 0, 3 forward -> sync on the third.
    bus.i_mode = MODE_WHEEL_BI;
    repeat (2) tick();
    check_vec("mode_chg_acc", {54'b0, dut.acc_q}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      cur_ab = rev(cur_ab);
      do_step(cur_ab, 1'b0, stp, syn);
      check_vec("rev_step", 64'(stp), 64'd1);
    end
    check_vec("rev_acc", {54'b0, dut.acc_q}, 64'h3F4);
    check_vec("rev_dir", 64'(bus.o_dir), 64'd0);
    check_vec("rev_pos", 64'(bus.o_pos), 64'd5);
    n_sync = 0;
    for (int k = 0; k < 4; k++) begin
      cur_ab = fwd(cur_ab);
      do_step(cur_ab, 1'b0, stp, syn);
      if (syn) n_sync++;
    end
    check_vec("bi_no_sync", 64'(n_sync), 64'd0);
    check_vec("bi_acc0", {54'b0, dut.acc_q}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      cur_ab = fwd(cur_ab);
      do_step(cur_ab, 1'b0, stp, syn);
      sync_pat[k] = syn;
    end
    check_vec("bi_sync_pat", 64'(sync_pat[2:0]), 64'b100);
    check_vec("bi_acc2", {54'b0, dut.acc_q}, 64'd2);
    check_vec("bi_frame", 64'(bus.o_frame_cnt), 64'd4);
    check_vec("bi_pos", 64'(bus.o_pos), 64'd12);

    // Timer, div=100: syncs at cycles 101 and 201 after the mode change.
    bus.i_mode = MODE_TIMER;
    bus.i_in_sync_div = 16'd100;
    n_sync = 0;
    t0 = 0;
    t1 = 0;
    for (int i = 1; i <= 250; i++) begin
      tick();
      if (bus.o_sync) begin
        if (n_sync == 0) t0 = i;
        else if (n_sync == 1) t1 = i;
        n_sync++;
      end
    end
    check_vec("tmr_count", 64'(n_sync), 64'd2);
    check_vec("tmr_first", 64'(t0), 64'd101);
    check_vec("tmr_second", 64'(t1), 64'd201);
    bus.i_in_sync_div = 16'd0;
    n_sync = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (bus.o_sync) n_sync++;
    end
    check_vec("tmr_div0", 64'(n_sync), 64'd0);
    check_vec("tmr_frame", 64'(bus.o_frame_cnt), 64'd6);
    bus.i_in_sync_div = 16'd1;
    n_sync = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.o_sync) n_sync++;
    end
    check_vec("tmr_div1", 64'(n_sync), 64'd5);
    check_vec("tmr_frame1", 64'(bus.o_frame_cnt), 64'd11);

    // Position clear and wrap, mode off.
    bus.i_mode = MODE_OFF;
    bus.i_pos_clr = 1'b1;
    tick();
    bus.i_pos_clr = 1'b0;
    check_vec("pos_clr", 64'(bus.o_pos), 64'd0);
    for (int k = 0; k < 5; k++) begin
      cur_ab = fwd(cur_ab);
      do_step(cur_ab, 1'b0, stp, syn);
    end
    check_vec("pos_5", 64'(bus.o_pos), 64'd5);
    cur_ab = fwd(cur_ab);
    do_step(cur_ab, 1'b1, stp, syn);
    check_vec("clr_step", 64'(stp), 64'd1);
    tick();
    check_vec("clr_wins", 64'(bus.o_pos), 64'd0);
    cur_ab = rev(cur_ab);
    do_step(cur_ab, 1'b0, stp, syn);
    check_vec("pos_neg1", 64'(bus.o_pos), 64'hFFFF_FFFF);
    cur_ab = fwd(cur_ab);
    do_step(cur_ab, 1'b0, stp, syn);
    check_vec("pos_wrap", 64'(bus.o_pos), 64'd0);
    check_vec("off_frame", 64'(bus.o_frame_cnt), 64'd11);

    // Asynchronous reset mid-operation.
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("arst_frame", 64'(bus.o_frame_cnt), 64'd0);
    check_vec("arst_dir", 64'(bus.o_dir), 64'd1);
    check_vec("arst_acc", {54'b0, dut.acc_q}, 64'd0);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/wheel_sync_gen.md
# wheel_sync_gen

Parametrised successor to the single-ratio wheel synchronizer: derives the scan-frame sync strobe for the acquisition front-end either from a quadrature wheel encoder or from an internal timer. Adds input debounce, signed position tracking, bidirectional wheel mode with backlash suppression, illegal-transition detection and a frame counter. Sits between the encoder pins and the frame/ADC sequencer; all outputs are in the `clk` domain.

## Interface
Parameters:
- FILT_DEPTH, 4: consecutive identical samples needed to accept a new A/B level (≥2).
- POS_W, 32: position counter width.
- DIV_W, 16: internal timer divider width.
- RATIO_W, 8: width of wheel_add / frame_dec.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_ch_a, i_ch_b  in  1  raw encoder phases, asynchronous.
- i_mode  in  2  00 off, 01 internal timer, 10 wheel forward-only, 11 wheel bidirectional.
- i_in_sync_div  in  DIV_W  timer period in clk cycles; 0 disables the timer.
- i_wheel_add  in  RATIO_W  accumulator increment per encoder step.
- i_frame_dec  in  RATIO_W  accumulator threshold/decrement per sync; 0 disables wheel sync.
- i_pos_clr  in  1  synchronous position clear.
- i_err_clr  in  1  clears o_err.
- o_step  out  1  one-cycle pulse per valid quadrature step.
- o_dir  out  1  1 = last step forward.
- o_pos  out  POS_W  signed position.
- o_sync  out  1  one-cycle frame strobe.
- o_frame_cnt  out  16  sync count, wraps.
- o_err  out  1  sticky illegal-transition flag.

## Operation
- Each phase: 2-FF synchroniser, then debounce; filtered level changes only after FILT_DEPTH equal consecutive synchronised samples.
- Priming: after reset the first stable {a,b} loads the decoder state without generating a step or error.
- Decode on filtered {a,b}; forward sequence 00→10→11→01→00 = +1, reverse = −1. Both bits changing in the same cycle: set o_err, no step, decoder state takes the new value.
- Position: o_pos ±1 per step, wraps modulo 2^POS_W. i_pos_clr has priority over a simultaneous step (result 0).
- Wheel accumulator acc: signed, RATIO_W+2 bits.
  - Mode 10: forward step → acc += wheel_add; reverse steps ignored.
  - Mode 11: forward += wheel_add, reverse −= wheel_add, saturating at the minimum value (no wrap).
  - After each addition, if frame_dec≠0 and acc ≥ frame_dec: acc −= frame_dec, fire o_sync. At most one sync per step.
- Timer (mode 01): counter 0..div−1; o_sync fires when the counter wraps from div−1 to 0. div=1 gives sync every cycle.
- Mode 00: no sync; decode/position continue.
- Any change of i_mode clears acc and the timer in that cycle; position, o_err and o_frame_cnt are kept.
- o_frame_cnt increments on every o_sync.
- i_err_clr clears o_err; a simultaneous new error wins (o_err stays 1).

## Timing
- Reset: o_step=0, o_dir=1, o_pos=0, o_sync=0, o_frame_cnt=0, o_err=0, acc=0, timer=0, decoder unprimed.
- Pin edge → filtered level: 2 + FILT_DEPTH cycles. Filtered change → o_step / o_pos / o_dir: 1 cycle. o_sync is asserted in the same cycle as the o_step that causes it.
- i_wheel_add, i_frame_dec and i_in_sync_div are sampled every cycle. A divider change takes effect on the next compare; if the counter is already ≥ the new div, the counter wraps on the next cycle.
- Asserting rst_n low mid-operation returns all state to reset values immediately.

## Structure
- Package sync_pkg holds the mode enum (MODE_OFF, MODE_TIMER, MODE_WHEEL_FWD, MODE_WHEEL_BI), the Gray-step lookup constants and the default parameter values.
- Sub-module quad_input_filter (2-FF synchroniser + FILT_DEPTH debounce), instantiated once per phase.
- Decode, accumulator, timer and counters live in the top module.

## Test plan
- Mode 10, add=3, dec=7, 7 forward steps → o_sync on steps 3, 5 and 7; acc=0; o_frame_cnt=3; o_pos=7.
- Mode 01, div=100 → o_sync every 100 cycles exactly; change to div=0 → no further sync.
- FILT_DEPTH=4, 2-cycle glitch on A → no o_step; 4-cycle stable change → one o_step 7 cycles after the pin edge.
- Filtered 00→11 → o_err=1, o_pos unchanged; i_err_clr → o_err=0.
- Mode 11, add=3, dec=7: 4 reverse steps (acc=−12), then 4 forward steps → no sync; 3 more forward steps → sync on the third.
- i_pos_clr together with a forward step at o_pos=5 → o_pos=0; o_pos=2^POS_W−1 plus a forward step → o_pos=0.
